// File: rtl/icache_ctrl_pkg.sv
// Shared types and address-field constants for the instruction cache controller.
package cache_pkg;
  localparam int ADDR_W         = 16;
  localparam int WORD_W         = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int WSEL_W         = 2;   // word-within-line select width
  localparam int WORD_LSB       = 1;   // Addr[2:1] selects the word
  localparam int INDEX_LSB      = 3;   // index starts right above the word select

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_e;

  typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

  // Tag is whatever is left of the address above index and word offset.
  function automatic int tag_w(input int index_bits);
    return ADDR_W - INDEX_LSB - index_bits;
  endfunction
endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side request port plus backing-memory port of the cache controller.
// master = requester and backing memory, slave = the cache controller.
interface icache_ctrl_if;
  import cache_pkg::*;
  logic [ADDR_W-1:0] Addr;
  logic [WORD_W-1:0] DataIn;
  logic              Rd;
  logic              Wr;
  logic [WORD_W-1:0] DataOut;
  logic              Done;
  logic              Stall;
  logic              CacheHit;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output Addr, DataIn, Rd, Wr, mem_ack, mem_rdata,
    input  DataOut, Done, Stall, CacheHit, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr, mem_ack, mem_rdata,
    output DataOut, Done, Stall, CacheHit, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/icache_ctrl_cache_array.sv
// Direct-mapped line storage: valid/tag/4-word data per line, async read port,
// one synchronous word write and one tag/valid write per cycle.
module cache_array
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int TAG_W      = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output line_t                 rd_line,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  word_we,
  input  logic [WSEL_W-1:0]     wr_word,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  line_we,
  input  logic                  line_valid,
  input  logic [TAG_W-1:0]      line_tag
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  line_t            data_q [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  // Valid bits are the only state cleared by reset.
  always_ff @(posedge clk) begin
    if (rst)          valid_q         <= '0;
    else if (line_we) valid_q[wr_idx] <= line_valid;
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (line_we) tag_q[wr_idx]           <= line_tag;
    if (word_we) data_q[wr_idx][wr_word] <= wr_data;
  end
endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-allocate, write-through/no-allocate cache controller.
// Hits answer combinationally in IDLE; misses fill words 0..3 in order.
module icache_ctrl
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  icache_ctrl_if.slave bus
);
  localparam int TAG_W = tag_w(INDEX_BITS);

  state_e            state_q, state_d;
  logic [WSEL_W-1:0] cnt_q, cnt_d;
  logic              op_rd_q, op_rd_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic [WSEL_W-1:0]     word;
  logic                  req_err, hit;

  logic                  arr_valid;
  logic [TAG_W-1:0]      arr_tag;
  line_t                 arr_line;
  logic                  a_word_we, a_line_we, a_line_valid;
  logic [WSEL_W-1:0]     a_wr_word;
  logic [WORD_W-1:0]     a_wr_data;

  // The requester holds Addr stable while stalled, so fields come straight off the port.
  assign word    = bus.Addr[WORD_LSB +: WSEL_W];
  assign idx     = bus.Addr[INDEX_LSB +: INDEX_BITS];
  assign tag     = bus.Addr[ADDR_W-1 -: TAG_W];
  assign hit     = arr_valid && (arr_tag == tag);
  assign req_err = (bus.Rd && bus.Wr) || (bus.Addr[0] && (bus.Rd || bus.Wr));

  cache_array #(.INDEX_BITS(INDEX_BITS), .TAG_W(TAG_W)) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (idx),
    .rd_valid  (arr_valid),
    .rd_tag    (arr_tag),
    .rd_line   (arr_line),
    .wr_idx    (idx),
    .word_we   (a_word_we),
    .wr_word   (a_wr_word),
    .wr_data   (a_wr_data),
    .line_we   (a_line_we),
    .line_valid(a_line_valid),
    .line_tag  (tag)
  );

  // State, fill word counter and the read/write flag for the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_rd_q <= op_rd_d;
    end
  end

  // Next state, handshake outputs and array write controls.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_rd_d       = op_rd_q;
    bus.DataOut   = '0;
    bus.Done      = 1'b0;
    bus.Stall     = 1'b0;
    bus.CacheHit  = 1'b0;
    bus.err       = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    a_word_we     = 1'b0;
    a_line_we     = 1'b0;
    a_line_valid  = 1'b0;
    a_wr_word     = cnt_q;
    a_wr_data     = bus.mem_rdata;
    // Reset quiets every output in the same cycle, including a pending mem_req.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (req_err) begin
            bus.err  = 1'b1;
            bus.Done = 1'b1;
          end else if (bus.Rd) begin
            if (hit) begin
              bus.Done     = 1'b1;
              bus.CacheHit = 1'b1;
              bus.DataOut  = arr_line[word];
            end else begin
              // Invalidate first so a fill cut short never exposes mixed old/new words.
              bus.Stall = 1'b1;
              state_d   = FILL;
              cnt_d     = '0;
              op_rd_d   = 1'b1;
              a_line_we = 1'b1;
            end
          end else if (bus.Wr) begin
            bus.Stall = 1'b1;
            state_d   = WRITE;
            op_rd_d   = 1'b0;
          end
        end
        FILL: begin
          bus.Stall    = 1'b1;
          bus.mem_req  = 1'b1;
          bus.mem_addr = {tag, idx, cnt_q, 1'b0};
          if (bus.mem_ack) begin
            a_word_we = 1'b1;
            cnt_d     = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              a_line_we    = 1'b1;
              a_line_valid = 1'b1;
              state_d      = RESP;
            end
          end
        end
        WRITE: begin
          bus.Stall     = 1'b1;
          bus.mem_req   = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = bus.Addr;
          bus.mem_wdata = bus.DataIn;
          if (bus.mem_ack) begin
            // Write-through: update a resident copy, never allocate.
            a_word_we = hit;
            a_wr_word = word;
            a_wr_data = bus.DataIn;
            state_d   = RESP;
          end
        end
        RESP: begin
          bus.Done    = 1'b1;
          bus.DataOut = op_rd_q ? arr_line[word] : '0;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule
